// File: rtl/vga_frame_capture.sv
// vga_frame_capture: VGA receive path that rebuilds pixel coordinates and writes a 2:1-decimated frame to RAM port A.
// Line-period checking is compiled in when VGA_CAPTURE_TIMING_CHECK_EN is defined; otherwise sync_err is tied low.
module vga_frame_capture #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  vgaRed,
  input  logic [3:0]  vgaGreen,
  input  logic [3:0]  vgaBlue,
  input  logic        capture_en,
  output logic        wea,
  output logic [16:0] addra,
  output logic [11:0] dina,
  output logic        busy,
  output logic        frame_done,
  output logic        sync_err
);

  localparam logic [9:0]  H_LO      = 10'(H_BACK);
  localparam logic [9:0]  H_HI      = 10'(H_BACK + H_VISIBLE);
  localparam logic [9:0]  V_LO      = 10'(V_BACK);
  localparam logic [9:0]  V_HI      = 10'(V_BACK + V_VISIBLE);
  localparam logic [16:0] ADDR_LAST = 17'((H_VISIBLE / 2) * (V_VISIBLE / 2) - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;
  state_t state, state_nxt;

  logic        hs_s1, vs_s1, hs_s2, vs_s2;
  logic [11:0] rgb_s1;
  logic [9:0]  h_pos, line_cnt, h_cur, line_cur, col, row;
  logic [16:0] addr_cur;
  logic        hs_rise, vs_rise, keep, capturing, last_wr, timing_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      hs_s2    <= 1'b1;
      vs_s2    <= 1'b1;
      rgb_s1   <= '0;
      h_pos    <= '0;
      line_cnt <= '0;
    end else begin
      hs_s1    <= hsync;
      vs_s1    <= vsync;
      hs_s2    <= hs_s1;
      vs_s2    <= vs_s1;
      rgb_s1   <= {vgaRed, vgaGreen, vgaBlue};
      h_pos    <= h_cur;
      line_cnt <= line_cur;
    end
  end

  assign hs_rise = hs_s1 & ~hs_s2;
  assign vs_rise = vs_s1 & ~vs_s2;

  // Coordinates are resolved for the pixel sitting in S1, so the sample that shows the rise is position 0.
  always_comb begin
    h_cur = (h_pos == '1) ? h_pos : h_pos + 10'd1;
    if (hs_rise) h_cur = '0;
    line_cur = line_cnt;
    if (vs_rise)      line_cur = '0;
    else if (hs_rise) line_cur = line_cnt + 10'd1;
  end

  assign col  = h_cur - H_LO;
  assign row  = line_cur - V_LO;
  assign keep = (h_cur >= H_LO) && (h_cur < H_HI) && (line_cur >= V_LO) && (line_cur < V_HI)
                && !col[0] && !row[0];

  // Full-size geometry uses the 256+64 shift-add; reduced geometries fall back to a constant multiply.
  generate
    if (H_VISIBLE == 640) begin : g_mul320
      assign addr_cur = ({8'd0, row[9:1]} << 8) + ({8'd0, row[9:1]} << 6) + {8'd0, col[9:1]};
    end else begin : g_mul_gen
      assign addr_cur = ({8'd0, row[9:1]} * 17'(H_VISIBLE / 2)) + {8'd0, col[9:1]};
    end
  endgenerate

  assign last_wr = wea && (addra == ADDR_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture_en) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (!capture_en)  state_nxt = IDLE;
        else if (vs_rise) state_nxt = CAPTURE;
      end
      CAPTURE: if (last_wr || timing_bad) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    capturing = (state == CAPTURE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      frame_done <= 1'b0;
    end else begin
      wea        <= capturing && keep && !timing_bad;
      frame_done <= capturing && last_wr;
      if (capturing && keep) begin
        addra <= addr_cur;
        dina  <= rgb_s1;
      end
    end
  end

`ifdef VGA_CAPTURE_TIMING_CHECK_EN
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  logic hs_seen;

  // The first rise after entering CAPTURE closes a line that began before the capture, so it is not judged.
  assign timing_bad = capturing && hs_rise && hs_seen && (h_pos != H_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_seen  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (!capturing)   hs_seen <= 1'b0;
      else if (hs_rise) hs_seen <= 1'b1;
      if (timing_bad) sync_err <= 1'b1;
    end
  end
`else
  assign timing_bad = 1'b0;
  assign sync_err   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: drives randomized frames on a reduced VGA geometry and checks every RAM write
// against pixel coordinates derived directly from the frame layout.
module tb_vga_frame_capture;

  localparam int HT  = 48;
  localparam int HV  = 32;
  localparam int HB  = 6;
  localparam int VT  = 24;
  localparam int VV  = 16;
  localparam int VB  = 5;
  localparam int HS0 = 36;
  localparam int HS1 = 42;
  localparam int VS0 = 17;
  localparam int VS1 = 19;
  localparam int HH  = HV / 2;
  localparam int NWR = HH * (VV / 2);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        capture_en = 1'b0;
  logic [3:0]  vgaRed = '0, vgaGreen = '0, vgaBlue = '0;
  logic        wea, busy, frame_done, sync_err;
  logic [16:0] addra;
  logic [11:0] dina;

  vga_frame_capture #(
    .H_VISIBLE(HV), .H_BACK(HB), .H_TOTAL(HT), .V_VISIBLE(VV), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .capture_en(capture_en), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int n_wr, n_done, data_err, cad_err, done_err, busy_low, wr_idx, first_cyc, px00_cyc;
  int row_off = 0;
  logic [16:0] first_addr, prev_addr;
  logic [11:0] first_data, d_11;
  logic        prev_wea = 1'b0;
  logic [11:0] pix [VT][HT];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_done = 0; data_err = 0; cad_err = 0; done_err = 0; busy_low = 0; wr_idx = 0;
    first_addr = '1; first_data = '1; d_11 = '0; first_cyc = -1;
  endtask

  // Write k must land at pixel (2*(k%HH), 2*(k/HH)+row_off) of the frame currently on the wire.
  task automatic observe();
    int ex, ey;
    if (!rst) begin
      wr_idx = 0;
      n_wr   = 0;
    end
    if (wea) begin
      if (prev_wea) cad_err++;
      ex = 2 * (wr_idx % HH);
      ey = 2 * (wr_idx / HH) + row_off;
      if (n_wr == 0) begin
        first_addr = addra;
        first_data = dina;
        first_cyc  = cyc;
      end
      if (int'(addra) != wr_idx || dina !== pix[ey][ex]) data_err++;
      if (addra == 17'(HH + 1)) d_11 = dina;
      wr_idx = (wr_idx + 1) % NWR;
      n_wr++;
    end
    if (frame_done) begin
      n_done++;
      if (!prev_wea || prev_addr != 17'(NWR - 1) || busy) done_err++;
    end
    if (!busy && n_done > 0) busy_low++;
    prev_wea  = wea;
    prev_addr = addra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic play(input bit pattern, input int short_v, input int rst_v, input int drop_v,
                      input bit late_vs);
    int hlen;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++)
        pix[v][h] = pattern ? {4'(h), 4'(v), 4'h5} : 12'($urandom);
    for (int v = 0; v < VT; v++) begin
      hlen = (v == short_v) ? HT - 1 : HT;
      for (int h = 0; h < hlen; h++) begin
        tick();
        if (v == rst_v) begin
          if (h == 0) rst = 1'b0;
          if (h == 2) check_eq("rst_mid_outputs", {wea, addra, dina, busy, frame_done, sync_err}, '0);
          if (h == 4) rst = 1'b1;
        end
        if (v == drop_v && h == 0) capture_en = 1'b0;
        if (v == 0 && h == 0) px00_cyc = cyc;
        hsync = !(h >= HS0 && h < HS1);
        vsync = !((v >= VS0 && v < VS1) || (late_vs && v == VS1 && h < HS1));
        {vgaRed, vgaGreen, vgaBlue} = pix[v][h];
      end
    end
  endtask

  initial begin
    clr();

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      {hsync, vsync, capture_en} = 3'($urandom);
      {vgaRed, vgaGreen, vgaBlue} = 12'($urandom);
      if (i % 2 == 1) check_eq("reset_outputs", {wea, addra, dina, busy, frame_done, sync_err}, '0);
    end
    hsync = 1'b1; vsync = 1'b1; capture_en = 1'b0;
    tick();
    rst = 1'b1;
    clr();
    play(0, -1, -1, -1, 0);
    play(0, -1, -1, -1, 0);
    check_eq("idle_writes", n_wr, 0);
    check_eq("idle_done", n_done, 0);
    check_eq("idle_busy", busy, 0);

    // Single capture of the coordinate pattern; enable drops inside CAPTURE and must be ignored.
    clr();
    capture_en = 1'b1;
    play(0, -1, -1, -1, 0);
    play(1, -1, -1, 0, 0);
    check_eq("frame_writes", n_wr, NWR);
    check_eq("frame_done_cnt", n_done, 1);
    check_eq("first_addr", first_addr, 0);
    check_eq("first_data", first_data, 12'h005);
    check_eq("row1_col1_data", d_11, {4'h2, 4'h2, 4'h5});
    check_eq("latency", first_cyc, px00_cyc + 2);
    check_eq("frame_data", data_err, 0);
    check_eq("frame_cadence", cad_err, 0);
    check_eq("frame_done_timing", done_err, 0);
    check_eq("frame_busy_after", busy, 0);
    clr();
    play(0, -1, -1, -1, 0);
    check_eq("disarmed_writes", n_wr, 0);

    clr();
    capture_en = 1'b1;
    repeat (4) play(0, -1, -1, -1, 0);
    check_eq("held_done_cnt", n_done, 3);
    check_eq("held_writes", n_wr, 3 * NWR);
    check_eq("held_busy_low", busy_low, 3);
    check_eq("held_data", data_err, 0);
    check_eq("held_done_timing", done_err, 0);
    check_eq("held_cadence", cad_err, 0);
    capture_en = 1'b0;
    play(0, -1, -1, -1, 0);
    check_eq("held_release_busy", busy, 0);

    clr();
    capture_en = 1'b1;
    play(0, -1, -1, -1, 0);
    play(0, -1, 8, -1, 0);
    check_eq("post_reset_writes", n_wr, 0);
    check_eq("post_reset_done", n_done, 0);
    play(0, -1, -1, 0, 0);
    check_eq("rearm_writes", n_wr, NWR);
    check_eq("rearm_first_addr", first_addr, 0);
    check_eq("rearm_done", n_done, 1);
    check_eq("rearm_data", data_err, 0);
    check_eq("rearm_sync_err", sync_err, 0);

    // Joint hsync/vsync rise: vsync wins, so row 0 is the source line one after the usual one.
    clr();
    capture_en = 1'b1;
    play(0, -1, -1, -1, 1);
    row_off = 1;
    play(0, -1, -1, 0, 0);
    row_off = 0;
    check_eq("joint_writes", n_wr, NWR);
    check_eq("joint_done", n_done, 1);
    check_eq("joint_data", data_err, 0);
    check_eq("joint_first_data", first_data, pix[1][0]);

    clr();
    capture_en = 1'b1;
    play(0, -1, -1, -1, 0);
    play(0, 4, -1, 0, 0);
`ifdef VGA_CAPTURE_TIMING_CHECK_EN
    check_eq("short_sync_err", sync_err, 1);
    check_eq("short_busy", busy, 0);
    check_eq("short_done", n_done, 0);
    check_eq("short_writes", n_wr, 3 * HH);
`else
    check_eq("short_sync_err", sync_err, 0);
    check_eq("short_done", n_done, 1);
    check_eq("short_writes", n_wr, NWR);
`endif
    check_eq("short_data", data_err, 0);
    clr();
    play(0, -1, -1, -1, 0);
    check_eq("after_short_writes", n_wr, 0);
`ifdef VGA_CAPTURE_TIMING_CHECK_EN
    check_eq("sync_err_sticky", sync_err, 1);
`else
    check_eq("sync_err_tied", sync_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
